// File: rtl/bsg_cam_pkg.sv
// Shared operation encodings for the n-read / 1-write CAM.
package bsg_cam_pkg;

  localparam logic [1:0] BSG_CAM_OP_WRITE = 2'd0;
  localparam logic [1:0] BSG_CAM_OP_INVAL = 2'd1;
  localparam logic [1:0] BSG_CAM_OP_NUKE  = 2'd2;
  localparam logic [1:0] BSG_CAM_OP_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    e_cam_write = BSG_CAM_OP_WRITE,
    e_cam_inval = BSG_CAM_OP_INVAL,
    e_cam_nuke  = BSG_CAM_OP_NUKE,
    e_cam_rsvd  = BSG_CAM_OP_RSVD
  } bsg_cam_op_e;

endpackage

// File: rtl/bsg_cam_nr1w_sync_repl_if.sv
// Write-port, read-port and status bundle of the CAM; master drives requests.
interface bsg_cam_nr1w_sync_repl_if
  #(parameter int tag_width_p  = 8,
    parameter int data_width_p = 16,
    parameter int rports_p     = 2);

  logic                             w_v_i;
  logic [1:0]                       w_op_i;
  logic [tag_width_p-1:0]           w_tag_i;
  logic [data_width_p-1:0]          w_data_i;
  logic [rports_p-1:0]              r_v_i;
  logic [rports_p*tag_width_p-1:0]  r_tag_i;
  logic [rports_p-1:0]              r_v_o;
  logic [rports_p*data_width_p-1:0] r_data_o;
  logic                             evict_v_o;
  logic [tag_width_p-1:0]           evict_tag_o;
  logic [data_width_p-1:0]          evict_data_o;
  logic                             empty_o;
  logic                             full_o;

  modport master (
    output w_v_i, w_op_i, w_tag_i, w_data_i, r_v_i, r_tag_i,
    input  r_v_o, r_data_o, evict_v_o, evict_tag_o, evict_data_o, empty_o, full_o
  );

  modport slave (
    input  w_v_i, w_op_i, w_tag_i, w_data_i, r_v_i, r_tag_i,
    output r_v_o, r_data_o, evict_v_o, evict_tag_o, evict_data_o, empty_o, full_o
  );

endinterface

// File: rtl/bsg_cam_victim_sel.sv
// Chooses the entry a WRITE lands in: the hit entry, else lowest free, else round-robin.
module bsg_cam_victim_sel
  #(parameter int els_p = 8)
  (input  logic             clk,
   input  logic             reset,
   input  logic [els_p-1:0] valid_i,
   input  logic [els_p-1:0] hit_i,
   input  logic             advance_i,
   input  logic             clear_i,
   output logic [els_p-1:0] sel_o,
   output logic             evict_sel_o);

  localparam int rr_w = $clog2(els_p);

  logic [rr_w-1:0]  rr_r;
  logic [els_p-1:0] free_oh;
  logic [els_p-1:0] rr_oh;
  logic             found;
  logic             any_hit;

  always_comb begin
    free_oh = '0;
    found   = 1'b0;
    for (int k = 0; k < els_p; k++) begin
      if (!valid_i[k] && !found) begin
        free_oh[k] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    rr_oh       = '0;
    rr_oh[rr_r] = 1'b1;
  end

  assign any_hit     = |hit_i;
  assign evict_sel_o = !any_hit && (&valid_i);

  always_comb begin
    sel_o = free_oh;
    if (any_hit)          sel_o = hit_i;
    else if (evict_sel_o) sel_o = rr_oh;
  end

  // The pointer wraps explicitly so non-power-of-2 depths never index past the end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rr_r <= '0;
    else if (clear_i)
      rr_r <= '0;
    else if (advance_i) begin
      if (rr_r == rr_w'(els_p-1)) rr_r <= '0;
      else                        rr_r <= rr_r + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_cam_nr1w_sync_repl.sv
// CAM with rports_p synchronous read ports, one write port, automatic replacement.
module bsg_cam_nr1w_sync_repl
  import bsg_cam_pkg::*;
  #(parameter int els_p        = 8,
    parameter int tag_width_p  = 8,
    parameter int data_width_p = 16,
    parameter int rports_p     = 2)
  (input logic clk,
   input logic reset,
   bsg_cam_nr1w_sync_repl_if.slave cam);

  logic [els_p-1:0]        valid_r;
  logic [tag_width_p-1:0]  tag_r  [els_p];
  logic [data_width_p-1:0] data_r [els_p];

  bsg_cam_op_e             op;
  logic                    write_v, inval_v, nuke_v;
  logic [els_p-1:0]        w_hit;
  logic [els_p-1:0]        w_sel;
  logic                    evict_sel;
  logic [tag_width_p-1:0]  victim_tag;
  logic [data_width_p-1:0] victim_data;

  logic                    evict_v_p1;
  logic [tag_width_p-1:0]  evict_tag_p1;
  logic [data_width_p-1:0] evict_data_p1;

  assign op      = bsg_cam_op_e'(cam.w_op_i);
  assign write_v = cam.w_v_i && (op == e_cam_write);
  assign inval_v = cam.w_v_i && (op == e_cam_inval);
  assign nuke_v  = cam.w_v_i && (op == e_cam_nuke);

  // p0: write-port tag match and victim choice
  always_comb begin
    for (int k = 0; k < els_p; k++)
      w_hit[k] = valid_r[k] && (tag_r[k] == cam.w_tag_i);
  end

  bsg_cam_victim_sel #(.els_p(els_p)) victim_sel (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (valid_r),
    .hit_i       (w_hit),
    .advance_i   (write_v && evict_sel),
    .clear_i     (nuke_v),
    .sel_o       (w_sel),
    .evict_sel_o (evict_sel)
  );

  always_comb begin
    victim_tag  = '0;
    victim_data = '0;
    for (int k = 0; k < els_p; k++) begin
      if (w_sel[k]) begin
        victim_tag  = victim_tag  | tag_r[k];
        victim_data = victim_data | data_r[k];
      end
    end
  end

  // p0 -> storage: valid bits are control and reset; tag/data payload is not
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      valid_r <= '0;
    else if (nuke_v)
      valid_r <= '0;
    else if (write_v)
      valid_r <= valid_r | w_sel;
    else if (inval_v)
      valid_r <= valid_r & ~w_hit;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < els_p; k++) begin
      if (write_v && w_sel[k]) begin
        tag_r[k]  <= cam.w_tag_i;
        data_r[k] <= cam.w_data_i;
      end
    end
  end

  // p0 -> p1: eviction report
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evict_v_p1    <= 1'b0;
      evict_tag_p1  <= '0;
      evict_data_p1 <= '0;
    end else begin
      evict_v_p1 <= write_v && evict_sel;
      if (write_v && evict_sel) begin
        evict_tag_p1  <= victim_tag;
        evict_data_p1 <= victim_data;
      end
    end
  end

  assign cam.evict_v_o    = evict_v_p1;
  assign cam.evict_tag_o  = evict_tag_p1;
  assign cam.evict_data_o = evict_data_p1;
  assign cam.empty_o      = ~|valid_r;
  assign cam.full_o       = &valid_r;

  for (genvar p = 0; p < rports_p; p++) begin : g_rd
    logic [tag_width_p-1:0]  tag_p0;
    logic [els_p-1:0]        hit_p0;
    logic [data_width_p-1:0] data_p0;
    logic                    r_v_p1;
    logic [data_width_p-1:0] r_data_p1;

    assign tag_p0 = cam.r_tag_i[p*tag_width_p +: tag_width_p];

    // p0: at most one valid entry matches, so a plain OR acts as the mux
    always_comb begin
      data_p0 = '0;
      for (int k = 0; k < els_p; k++) begin
        hit_p0[k] = valid_r[k] && (tag_r[k] == tag_p0);
        if (hit_p0[k]) data_p0 = data_p0 | data_r[k];
      end
    end

    // p0 -> p1: registered read result, sees pre-write contents
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_v_p1    <= 1'b0;
        r_data_p1 <= '0;
      end else begin
        r_v_p1 <= cam.r_v_i[p] && (|hit_p0);
        if (cam.r_v_i[p]) r_data_p1 <= data_p0;
      end
    end

    assign cam.r_v_o[p]                                = r_v_p1;
    assign cam.r_data_o[p*data_width_p +: data_width_p] = r_data_p1;
  end

endmodule

// File: tb/tb_bsg_cam_nr1w_sync_repl.sv
// Bench for bsg_cam_nr1w_sync_repl: directed scenarios plus random traffic against an entry-table model.
module tb_bsg_cam_nr1w_sync_repl;

  localparam int ELS = 4;
  localparam int TW  = 8;
  localparam int DW  = 16;
  localparam int RP  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bsg_cam_nr1w_sync_repl_if #(.tag_width_p(TW), .data_width_p(DW), .rports_p(RP)) cam_if ();

  bsg_cam_nr1w_sync_repl #(.els_p(ELS), .tag_width_p(TW), .data_width_p(DW), .rports_p(RP)) dut (
    .clk   (clk),
    .reset (reset),
    .cam   (cam_if)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a table of entries with the replacement rules applied directly.
  bit             m_valid [ELS];
  logic [TW-1:0]  m_tag   [ELS];
  logic [DW-1:0]  m_data  [ELS];
  int             m_rr = 0;
  logic           exp_rv  [RP] = '{default: 1'b0};
  logic [DW-1:0]  exp_rd  [RP] = '{default: '0};
  logic           exp_ev = 1'b0;
  logic [TW-1:0]  exp_et = '0;
  logic [DW-1:0]  exp_ed = '0;

  always @(posedge clk or negedge reset) begin : model
    int            k_hit, k_free, k;
    logic [TW-1:0] rt;
    if (!reset) begin
      for (int i = 0; i < ELS; i++) m_valid[i] = 1'b0;
      m_rr   = 0;
      exp_ev = 1'b0;
      for (int p = 0; p < RP; p++) exp_rv[p] = 1'b0;
    end else begin
      for (int p = 0; p < RP; p++) begin
        exp_rv[p] = 1'b0;
        if (cam_if.r_v_i[p]) begin
          rt = cam_if.r_tag_i[p*TW +: TW];
          for (int i = 0; i < ELS; i++)
            if (m_valid[i] && m_tag[i] == rt) begin
              exp_rv[p] = 1'b1;
              exp_rd[p] = m_data[i];
            end
        end
      end
      exp_ev = 1'b0;
      if (cam_if.w_v_i) begin
        k_hit = -1;
        k_free = -1;
        for (int i = 0; i < ELS; i++) begin
          if (m_valid[i] && m_tag[i] == cam_if.w_tag_i) k_hit = i;
          if (!m_valid[i] && k_free < 0) k_free = i;
        end
        case (cam_if.w_op_i)
          2'd0: begin
            if (k_hit >= 0) k = k_hit;
            else if (k_free >= 0) k = k_free;
            else begin
              k = m_rr;
              exp_ev = 1'b1;
              exp_et = m_tag[k];
              exp_ed = m_data[k];
              m_rr = (m_rr + 1) % ELS;
            end
            m_valid[k] = 1'b1;
            m_tag[k]   = cam_if.w_tag_i;
            m_data[k]  = cam_if.w_data_i;
          end
          2'd1: if (k_hit >= 0) m_valid[k_hit] = 1'b0;
          2'd2: begin
            for (int i = 0; i < ELS; i++) m_valid[i] = 1'b0;
            m_rr = 0;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin : compare
    int cnt;
    cnt = 0;
    for (int i = 0; i < ELS; i++) cnt += int'(m_valid[i]);
    for (int p = 0; p < RP; p++) begin
      chk("r_v_o", 32'(cam_if.r_v_o[p]), 32'(exp_rv[p]));
      if (exp_rv[p]) chk("r_data_o", 32'(cam_if.r_data_o[p*DW +: DW]), 32'(exp_rd[p]));
    end
    chk("evict_v_o", 32'(cam_if.evict_v_o), 32'(exp_ev));
    if (exp_ev) begin
      chk("evict_tag_o", 32'(cam_if.evict_tag_o), 32'(exp_et));
      chk("evict_data_o", 32'(cam_if.evict_data_o), 32'(exp_ed));
    end
    chk("empty_o", 32'(cam_if.empty_o), 32'(cnt == 0));
    chk("full_o", 32'(cam_if.full_o), 32'(cnt == ELS));
  end

  task automatic drive(input logic wv, input logic [1:0] wop, input logic [TW-1:0] wt,
                       input logic [DW-1:0] wd, input logic [RP-1:0] rv,
                       input logic [TW-1:0] t0, input logic [TW-1:0] t1);
    cam_if.w_v_i    = wv;
    cam_if.w_op_i   = wop;
    cam_if.w_tag_i  = wt;
    cam_if.w_data_i = wd;
    cam_if.r_v_i    = rv;
    cam_if.r_tag_i  = {t1, t0};
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, '0, '0, '0, '0, '0);
  endtask

  logic [TW-1:0] ev_tag  [5] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [DW-1:0] ev_data [5] = '{16'hdead, 16'hcafe, 16'h1234, 16'h5678, 16'h4444};

  initial begin
    logic [TW-1:0] t;
    int            r;
    cam_if.w_v_i    = 1'b0;
    cam_if.w_op_i   = 2'd0;
    cam_if.w_tag_i  = '0;
    cam_if.w_data_i = '0;
    cam_if.r_v_i    = '0;
    cam_if.r_tag_i  = '0;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("reset r_v_o", 32'(cam_if.r_v_o), 32'h0);
    chk("reset empty_o", 32'(cam_if.empty_o), 32'h1);
    chk("reset full_o", 32'(cam_if.full_o), 32'h0);
    chk("reset evict_v_o", 32'(cam_if.evict_v_o), 32'h0);
    reset = 1'b1;

    // Fill and read
    drive(1'b1, 2'd0, 8'h00, 16'hdead, 2'b00, '0, '0);
    drive(1'b1, 2'd0, 8'h11, 16'hbeef, 2'b00, '0, '0);
    drive(1'b1, 2'd0, 8'h22, 16'h1234, 2'b00, '0, '0);
    drive(1'b1, 2'd0, 8'h33, 16'h5678, 2'b00, '0, '0);
    drive(1'b0, 2'd0, '0, '0, 2'b11, 8'h22, 8'h00);
    chk("fill r_v_o", 32'(cam_if.r_v_o), 32'h3);
    chk("fill data0", 32'(cam_if.r_data_o[15:0]), 32'h1234);
    chk("fill data1", 32'(cam_if.r_data_o[31:16]), 32'hdead);
    chk("fill full_o", 32'(cam_if.full_o), 32'h1);

    // Update on hit
    drive(1'b1, 2'd0, 8'h11, 16'hcafe, 2'b00, '0, '0);
    chk("update evict_v_o", 32'(cam_if.evict_v_o), 32'h0);
    drive(1'b0, 2'd0, '0, '0, 2'b11, 8'h11, 8'h00);
    chk("update data0", 32'(cam_if.r_data_o[15:0]), 32'hcafe);
    chk("update full_o", 32'(cam_if.full_o), 32'h1);
    drive(1'b0, 2'd0, '0, '0, 2'b11, 8'h22, 8'h33);
    chk("update others hit", 32'(cam_if.r_v_o), 32'h3);

    // Round-robin eviction with wrap
    for (int i = 0; i < 5; i++) begin
      t = 8'h44 + 8'(8'h11 * i);
      drive(1'b1, 2'd0, t, {t, t}, 2'b00, '0, '0);
      chk("rr evict_v_o", 32'(cam_if.evict_v_o), 32'h1);
      chk("rr evict_tag_o", 32'(cam_if.evict_tag_o), 32'(ev_tag[i]));
      chk("rr evict_data_o", 32'(cam_if.evict_data_o), 32'(ev_data[i]));
    end
    idle();
    chk("rr evict_v_o drop", 32'(cam_if.evict_v_o), 32'h0);

    // INVAL and refill
    drive(1'b1, 2'd1, 8'h66, '0, 2'b00, '0, '0);
    drive(1'b1, 2'd1, 8'h99, '0, 2'b01, 8'h66, '0);
    chk("inval read miss", 32'(cam_if.r_v_o[0]), 32'h0);
    chk("inval full_o", 32'(cam_if.full_o), 32'h0);
    drive(1'b1, 2'd0, 8'haa, 16'haaaa, 2'b00, '0, '0);
    chk("refill evict_v_o", 32'(cam_if.evict_v_o), 32'h0);
    chk("refill full_o", 32'(cam_if.full_o), 32'h1);

    // Same-cycle read/write and NUKE
    drive(1'b1, 2'd0, 8'hbb, 16'hbbbb, 2'b01, 8'hbb, '0);
    chk("rw same-cycle miss", 32'(cam_if.r_v_o[0]), 32'h0);
    drive(1'b0, 2'd0, '0, '0, 2'b01, 8'hbb, '0);
    chk("rw next hit", 32'(cam_if.r_v_o[0]), 32'h1);
    chk("rw next data", 32'(cam_if.r_data_o[15:0]), 32'hbbbb);
    drive(1'b1, 2'd2, '0, '0, 2'b01, 8'h77, '0);
    chk("nuke old hit", 32'(cam_if.r_v_o[0]), 32'h1);
    chk("nuke old data", 32'(cam_if.r_data_o[15:0]), 32'h7777);
    chk("nuke empty_o", 32'(cam_if.empty_o), 32'h1);
    drive(1'b0, 2'd0, '0, '0, 2'b11, 8'h77, 8'h88);
    chk("nuke reads miss", 32'(cam_if.r_v_o), 32'h0);
    for (int i = 1; i <= 4; i++)
      drive(1'b1, 2'd0, 8'(i), 16'(i * 16'h0101), 2'b00, '0, '0);
    drive(1'b1, 2'd0, 8'h05, 16'h0505, 2'b01, 8'h02, '0);
    chk("post-nuke evict_tag_o", 32'(cam_if.evict_tag_o), 32'h01);
    chk("post-nuke evict_v_o", 32'(cam_if.evict_v_o), 32'h1);
    chk("pre-reset r_v_o", 32'(cam_if.r_v_o[0]), 32'h1);

    // Async reset mid-stream
    reset = 1'b0;
    #1;
    chk("async r_v_o", 32'(cam_if.r_v_o), 32'h0);
    chk("async evict_v_o", 32'(cam_if.evict_v_o), 32'h0);
    chk("async full_o", 32'(cam_if.full_o), 32'h0);
    chk("async empty_o", 32'(cam_if.empty_o), 32'h1);
    cam_if.w_v_i = 1'b0;
    cam_if.r_v_i = '0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    drive(1'b0, 2'd0, '0, '0, 2'b01, 8'h03, '0);
    chk("after reset miss", 32'(cam_if.r_v_o[0]), 32'h0);

    // Random traffic over a small tag space to force hits, evictions and invalidates
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 3) != 0),
            (r < 10) ? 2'd0 : (r < 13) ? 2'd1 : (r == 13) ? 2'd2 : 2'd3,
            8'($urandom_range(0, 9)), 16'($urandom),
            2'($urandom_range(0, 3)),
            8'($urandom_range(0, 9)), 8'($urandom_range(0, 9)));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
